// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage decode, hazard-control and pipeline-enable signals between the
// decode stage and the stall controller.
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic             valid_ID;
    logic [4:0]       rs1_addr_ID;
    logic             rs1_used_ID;
    logic [4:0]       rs2_addr_ID;
    logic             rs2_used_ID;
    logic [4:0]       rd_addr_ID;
    logic             RegWrite_ID;
    logic             redirect_EX;
    logic             mem_busy;
    logic             PC_en;
    logic             en_IFID;
    logic             NOP_IFID;
    logic             en_IDEX;
    logic             NOP_IDEX;
    logic             data_stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Controller side: consumes decode info, drives the pipeline enables.
    modport master (
        input  valid_ID, rs1_addr_ID, rs1_used_ID, rs2_addr_ID, rs2_used_ID,
               rd_addr_ID, RegWrite_ID, redirect_EX, mem_busy,
        output PC_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, data_stall,
               stall_cnt, flush_cnt
    );

    modport slave (
        output valid_ID, rs1_addr_ID, rs1_used_ID, rs2_addr_ID, rs2_used_ID,
               rd_addr_ID, RegWrite_ID, redirect_EX, mem_busy,
        input  PC_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, data_stall,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for a forwarding-less 5-stage pipeline: tracks
// in-flight destination registers and stalls ID on RAW hazards.
module hazard_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic           clk_HZ,
    input  logic           rst_n_HZ,
    hazard_stall_if.master hs
);
    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
    } slot_t;

    typedef enum logic [1:0] {
        MODE_ISSUE,
        MODE_STALL,
        MODE_FLUSH,
        MODE_FREEZE
    } mode_e;

    localparam slot_t BUBBLE = '{wr: 1'b0, rd: 5'd0};

    slot_t            sb_ex_q, sb_ex_d;
    slot_t            sb_mem_q, sb_mem_d;
    slot_t            sb_wb_q, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    mode_e            mode;
    logic             hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // WB slot is ignored when the register file writes before it reads.
    function automatic logic in_flight(input logic [4:0] r, input slot_t ex,
                                       input slot_t mem, input slot_t wb);
        logic hit;
        hit = (ex.wr && ex.rd == r) || (mem.wr && mem.rd == r);
        if (!WB_BYPASS) hit = hit || (wb.wr && wb.rd == r);
        return hit;
    endfunction

    always_comb begin
        hz = hs.valid_ID &&
             ((hs.rs1_used_ID && hs.rs1_addr_ID != 5'd0 &&
               in_flight(hs.rs1_addr_ID, sb_ex_q, sb_mem_q, sb_wb_q)) ||
              (hs.rs2_used_ID && hs.rs2_addr_ID != 5'd0 &&
               in_flight(hs.rs2_addr_ID, sb_ex_q, sb_mem_q, sb_wb_q)));
        if (hs.mem_busy)         mode = MODE_FREEZE;
        else if (hs.redirect_EX) mode = MODE_FLUSH;
        else if (hz)             mode = MODE_STALL;
        else                     mode = MODE_ISSUE;
    end

    always_comb begin
        hs.PC_en      = 1'b1;
        hs.en_IFID    = 1'b1;
        hs.NOP_IFID   = 1'b0;
        hs.en_IDEX    = 1'b1;
        hs.NOP_IDEX   = 1'b0;
        hs.data_stall = 1'b0;
        case (mode)
            MODE_FREEZE: begin
                hs.PC_en   = 1'b0;
                hs.en_IFID = 1'b0;
                hs.en_IDEX = 1'b0;
            end
            MODE_FLUSH: begin
                hs.NOP_IFID = 1'b1;
                hs.NOP_IDEX = 1'b1;
            end
            MODE_STALL: begin
                hs.PC_en      = 1'b0;
                hs.en_IFID    = 1'b0;
                hs.NOP_IDEX   = 1'b1;
                hs.data_stall = 1'b1;
            end
            default: ;
        endcase
        // Reset presents a flushed, non-advancing pipeline.
        if (!rst_n_HZ) begin
            hs.PC_en      = 1'b0;
            hs.en_IFID    = 1'b1;
            hs.NOP_IFID   = 1'b1;
            hs.en_IDEX    = 1'b1;
            hs.NOP_IDEX   = 1'b1;
            hs.data_stall = 1'b0;
        end
    end

    always_comb begin
        sb_ex_d     = sb_ex_q;
        sb_mem_d    = sb_mem_q;
        sb_wb_d     = sb_wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mode != MODE_FREEZE) begin
            sb_mem_d = sb_ex_q;
            sb_wb_d  = sb_mem_q;
            sb_ex_d  = BUBBLE;
            case (mode)
                MODE_FLUSH: flush_cnt_d = sat_inc(flush_cnt_q);
                MODE_STALL: stall_cnt_d = sat_inc(stall_cnt_q);
                default: begin
                    sb_ex_d.wr = hs.valid_ID && hs.RegWrite_ID && (hs.rd_addr_ID != 5'd0);
                    sb_ex_d.rd = hs.rd_addr_ID;
                end
            endcase
        end
    end

    always_ff @(posedge clk_HZ) begin
        if (!rst_n_HZ) begin
            sb_ex_q     <= BUBBLE;
            sb_mem_q    <= BUBBLE;
            sb_wb_q     <= BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hs.stall_cnt = stall_cnt_q;
    assign hs.flush_cnt = flush_cnt_q;
endmodule
